branch_resolve_queue: RTL

- Resolution-side partner of the per-branch saturating-counter predictor.
- Records each predicted branch at fetch in an in-order FIFO (PC + predicted direction).
- Matches each entry against the actual outcome from execute, in program order.
- Emits the registered update/taken pulse that trains the predictor, flags mispredicts, and keeps saturating statistics counters.

---
 rtl/branch_resolve_queue_if.sv | 39 +++
 rtl/branch_resolve_queue.sv | 128 ++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// Bundle of the fetch-push, execute-resolve and predictor-update signals
// of the branch resolve queue. The slave side is the queue itself.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    localparam int CNT_SZ = $clog2(DEPTH + 1);

    logic              push_valid;
    logic [PC_W-1:0]   push_pc;
    logic              push_pred;
    logic              push_ready;
    logic              res_valid;
    logic              res_taken;
    logic              res_ready;
    logic              flush;
    logic              upd;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_pc;
    logic              mispredict;
    logic [CNT_SZ-1:0] count;
    logic [CNT_W-1:0]  mispred_cnt;
    logic [CNT_W-1:0]  resolved_cnt;

    // Fetch/execute side: drives pushes, resolves and flush.
    modport master (
        output push_valid, push_pc, push_pred, res_valid, res_taken, flush,
        input  push_ready, res_ready, upd, upd_taken, upd_pc, mispredict,
               count, mispred_cnt, resolved_cnt
    );

    // Queue side.
    modport slave (
        input  push_valid, push_pc, push_pred, res_valid, res_taken, flush,
        output push_ready, res_ready, upd, upd_taken, upd_pc, mispredict,
               count, mispred_cnt, resolved_cnt
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches. Each entry (PC + predicted
// direction) is matched against the execute outcome in program order and
// produces a registered one-cycle training pulse for the predictor, a
// mispredict flag and saturating statistics.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_resolve_queue_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_SZ = $clog2(DEPTH + 1);
    localparam logic [CNT_SZ-1:0] FULL_CNT = CNT_SZ'(DEPTH);

    // Entry layout: {pc, predicted direction}
    logic [PC_W:0]       r_mem [DEPTH];

    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_SZ-1:0]   r_count;
    logic                r_upd;
    logic                r_upd_taken;
    logic [PC_W-1:0]     r_upd_pc;
    logic                r_mispredict;
    logic [CNT_W-1:0]    r_mispred_cnt;
    logic [CNT_W-1:0]    r_resolved_cnt;

    logic                w_push_ready;
    logic                w_res_ready;
    logic                w_push_acc;
    logic                w_res_acc;
    logic [PC_W:0]       w_rd_entry;
    logic [PC_W-1:0]     w_rd_pc;
    logic                w_rd_pred;
    logic                w_mispred;

    // Readiness is purely a function of the registered occupancy, so a
    // same-cycle resolve never frees a slot for a push and vice versa.
    assign w_push_ready = (r_count != FULL_CNT);
    assign w_res_ready  = (r_count != '0);

    // A flush squashes the push arriving in the same cycle.
    assign w_push_acc = bus.push_valid & w_push_ready & ~bus.flush;
    assign w_res_acc  = bus.res_valid  & w_res_ready;

    assign w_rd_entry = r_mem[r_rptr];
    assign w_rd_pc    = w_rd_entry[PC_W:1];
    assign w_rd_pred  = w_rd_entry[0];
    assign w_mispred  = w_rd_pred ^ bus.res_taken;

    // Entry storage write; no reset so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wptr] <= {bus.push_pc, bus.push_pred};
        end
    end

    // Pointer and occupancy tracking; flush realigns read onto write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (bus.flush) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_res_acc) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                case ({w_push_acc, w_res_acc})
                    2'b10:   r_count <= r_count + CNT_SZ'(1);
                    2'b01:   r_count <= r_count - CNT_SZ'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Registered predictor update; pc/taken hold between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_upd        <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_upd_pc     <= '0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd        <= w_res_acc;
            r_mispredict <= w_res_acc & w_mispred;
            if (w_res_acc) begin
                r_upd_taken <= bus.res_taken;
                r_upd_pc    <= w_rd_pc;
            end
        end
    end

    // Saturating statistics; unaffected by flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mispred_cnt  <= '0;
            r_resolved_cnt <= '0;
        end else begin
            if (w_res_acc && (r_resolved_cnt != '1)) begin
                r_resolved_cnt <= r_resolved_cnt + CNT_W'(1);
            end
            if (w_res_acc && w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.push_ready   = w_push_ready;
    assign bus.res_ready    = w_res_ready;
    assign bus.upd          = r_upd;
    assign bus.upd_taken    = r_upd_taken;
    assign bus.upd_pc       = r_upd_pc;
    assign bus.mispredict   = r_mispredict;
    assign bus.count        = r_count;
    assign bus.mispred_cnt  = r_mispred_cnt;
    assign bus.resolved_cnt = r_resolved_cnt;
endmodule
